// File: rtl/sequenceur_mesure.sv
// Ultrasonic telemeter measurement sequencer.
// Fires the sensor trigger at a fixed rate, waits for the echo, measures
// the echo width in centimetres and publishes it with a one-cycle strobe.
// Missing or stuck echoes abort the cycle with a Timeout strobe.
module sequenceur_mesure #(
    parameter int unsigned TRIG_CYCLES   = 500,
    parameter int unsigned US_DIV        = 50,
    parameter int unsigned CM_US         = 58,
    parameter int unsigned TIMEOUT_US    = 30000,
    parameter int unsigned PERIOD_CYCLES = 2500000,
    parameter int unsigned DIST_W        = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic              Echo,
    output logic              Trig,
    output logic [DIST_W-1:0] Distance,
    output logic              Valid,
    output logic              Timeout,
    output logic              Busy
);

    localparam int unsigned TRIG_W  = $clog2(TRIG_CYCLES + 1);
    localparam int unsigned PRESC_W = $clog2(US_DIV + 1);
    localparam int unsigned US_W    = $clog2(TIMEOUT_US + 1);
    localparam int unsigned CMD_W   = $clog2(CM_US + 1);
    localparam int unsigned PER_W   = $clog2(PERIOD_CYCLES + 1);

    localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(US_DIV - 1);
    localparam logic [US_W-1:0]    US_LIMIT   = US_W'(TIMEOUT_US);
    localparam logic [CMD_W-1:0]   CMD_LAST   = CMD_W'(CM_US - 1);
    localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    state_t              state;
    logic                echo_m;
    logic                echo_s;
    logic [TRIG_W-1:0]   trig_cnt;
    logic [PER_W-1:0]    period_cnt;
    logic [PRESC_W-1:0]  presc;
    logic [US_W-1:0]     us_cnt;
    logic [CMD_W-1:0]    cm_div;
    logic [DIST_W-1:0]   cm_cnt;

    logic                presc_wrap;
    logic [PRESC_W-1:0]  presc_nxt;
    logic [US_W-1:0]     us_nxt;
    logic [CMD_W-1:0]    cm_div_nxt;
    logic [DIST_W-1:0]   cm_nxt;
    logic                cm_wrap;
    logic                period_done;

    // Two-flop synchronizer for the asynchronous echo input.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= Echo;
            echo_s <= echo_m;
        end
    end

    // Next values of the us/cm timebase if the current cycle is counted.
    // The fall cycle is counted too, so Distance reflects all N high cycles.
    always_comb begin
        presc_wrap = (presc == PRESC_LAST);
        presc_nxt  = presc_wrap ? '0 : presc + 1'b1;
        us_nxt     = presc_wrap ? us_cnt + 1'b1 : us_cnt;
        cm_wrap    = presc_wrap && (cm_div == CMD_LAST);
        cm_div_nxt = cm_div;
        if (presc_wrap) begin
            cm_div_nxt = (cm_div == CMD_LAST) ? '0 : cm_div + 1'b1;
        end
        cm_nxt      = (cm_wrap && (cm_cnt != '1)) ? cm_cnt + 1'b1 : cm_cnt;
        period_done = (period_cnt == PER_LAST);
    end

    // Acquisition FSM with registered Trig/Busy/Distance and strobes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            Trig       <= 1'b0;
            Distance   <= '0;
            Valid      <= 1'b0;
            Timeout    <= 1'b0;
            Busy       <= 1'b0;
            trig_cnt   <= '0;
            period_cnt <= '0;
            presc      <= '0;
            us_cnt     <= '0;
            cm_div     <= '0;
            cm_cnt     <= '0;
        end else begin
            Valid   <= 1'b0;
            Timeout <= 1'b0;
            if ((state != IDLE) && !period_done) begin
                period_cnt <= period_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (Enable) begin
                        state      <= TRIG;
                        Trig       <= 1'b1;
                        Busy       <= 1'b1;
                        trig_cnt   <= '0;
                        period_cnt <= '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt == TRIG_LAST) begin
                        state  <= WAIT_ECHO;
                        Trig   <= 1'b0;
                        presc  <= '0;
                        us_cnt <= '0;
                    end else begin
                        trig_cnt <= trig_cnt + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    if (echo_s) begin
                        state  <= MEASURE;
                        presc  <= '0;
                        us_cnt <= '0;
                        cm_div <= '0;
                        cm_cnt <= '0;
                    end else if (us_nxt == US_LIMIT) begin
                        state   <= HOLDOFF;
                        Timeout <= 1'b1;
                    end else begin
                        presc  <= presc_nxt;
                        us_cnt <= us_nxt;
                    end
                end
                MEASURE: begin
                    if (!echo_s) begin
                        state    <= HOLDOFF;
                        Distance <= cm_nxt;
                        Valid    <= 1'b1;
                    end else if (us_nxt == US_LIMIT) begin
                        state   <= HOLDOFF;
                        Timeout <= 1'b1;
                    end else begin
                        presc  <= presc_nxt;
                        us_cnt <= us_nxt;
                        cm_div <= cm_div_nxt;
                        cm_cnt <= cm_nxt;
                    end
                end
                HOLDOFF: begin
                    if (period_done && !echo_s) begin
                        if (Enable) begin
                            state      <= TRIG;
                            Trig       <= 1'b1;
                            trig_cnt   <= '0;
                            period_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Trig  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenceur_mesure.sv
// Directed bench for sequenceur_mesure with small timing parameters.
module tb_sequenceur_mesure;

    localparam int unsigned TRIG_CYCLES   = 5;
    localparam int unsigned US_DIV        = 2;
    localparam int unsigned CM_US         = 3;
    localparam int unsigned TIMEOUT_US    = 1000;
    localparam int unsigned PERIOD_CYCLES = 5000;
    localparam int unsigned DIST_W        = 8;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Enable = 1'b0;
    logic              Echo = 1'b0;
    logic              Trig;
    logic [DIST_W-1:0] Distance;
    logic              Valid;
    logic              Timeout;
    logic              Busy;

    sequenceur_mesure #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .US_DIV        (US_DIV),
        .CM_US         (CM_US),
        .TIMEOUT_US    (TIMEOUT_US),
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .DIST_W        (DIST_W)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Enable   (Enable),
        .Echo     (Echo),
        .Trig     (Trig),
        .Distance (Distance),
        .Valid    (Valid),
        .Timeout  (Timeout),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Event monitor, sampled on the falling edge.
    int trig_rises = 0, trig_falls = 0, valid_cnt = 0, to_cnt = 0, busy_falls = 0;
    int trig_rise_cyc = 0, prev_rise_cyc = 0, trig_fall_cyc = 0, to_cyc = 0, busy_fall_cyc = 0;
    int viol = 0;
    logic prev_trig = 1'b0, prev_busy = 1'b0, prev_strobe = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Trig && !prev_trig) begin
            prev_rise_cyc = trig_rise_cyc;
            trig_rise_cyc = cyc;
            trig_rises++;
        end
        if (!Trig && prev_trig) begin
            trig_fall_cyc = cyc;
            trig_falls++;
        end
        if (!Busy && prev_busy) begin
            busy_fall_cyc = cyc;
            busy_falls++;
        end
        if (Valid) valid_cnt++;
        if (Timeout) begin
            to_cyc = cyc;
            to_cnt++;
        end
        if (Valid && Timeout) viol++;
        if ((Valid || Timeout) && prev_strobe) viol++;
        prev_strobe = Valid || Timeout;
        prev_trig   = Trig;
        prev_busy   = Busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic int counter(input int which);
        case (which)
            0:       return trig_rises;
            1:       return trig_falls;
            2:       return valid_cnt;
            3:       return to_cnt;
            default: return busy_falls;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int target, input int budget);
        int i;
        i = 0;
        while (counter(which) < target && i < budget) begin
            @(posedge Clk);
            #1;
            i++;
        end
        chk(tag, 32'(counter(which) >= target), 1);
    endtask

    // One measurement: echo rises ~20 cycles after Trig falls, high for `high` cycles.
    task automatic measure(input string tag, input int high, input int exp);
        int nv, nt;
        nv = valid_cnt + 1;
        nt = to_cnt;
        wait_for({tag, "_trig_fall"}, 1, trig_falls + 1, 7000);
        tick(20);
        Echo = 1'b1;
        tick(high);
        Echo = 1'b0;
        wait_for({tag, "_valid_wait"}, 2, nv, 50);
        chk({tag, "_distance"}, 32'(Distance), exp);
        tick(3);
        chk({tag, "_single_valid"}, valid_cnt, nv);
        chk({tag, "_no_timeout"}, to_cnt, nt);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv, nt, r0, d, b0;

        // Reset state
        tick(3);
        chk("rst_trig", 32'(Trig), 0);
        chk("rst_distance", 32'(Distance), 0);
        chk("rst_valid", 32'(Valid), 0);
        chk("rst_timeout", 32'(Timeout), 0);
        chk("rst_busy", 32'(Busy), 0);

        // Enable sampled in IDLE -> Trig and Busy on the next cycle
        Reset_n = 1'b1;
        Enable  = 1'b1;
        tick(1);
        chk("start_trig", 32'(Trig), 1);
        chk("start_busy", 32'(Busy), 1);

        // Nominal: 60 cycles -> 30 us -> 10 cm
        measure("nominal", 60, 10);
        chk("trig_width", trig_fall_cyc - trig_rise_cyc, TRIG_CYCLES);

        // Truncation
        measure("trunc65", 65, 10);
        chk("period_nominal", trig_rise_cyc - prev_rise_cyc, PERIOD_CYCLES);
        measure("trunc66", 66, 11);

        // No echo: timeout ~2000 cycles after Trig falls
        nv = valid_cnt;
        r0 = trig_rises;
        wait_for("noecho_trig_fall", 1, trig_falls + 1, 7000);
        wait_for("noecho_timeout_wait", 3, to_cnt + 1, 2500);
        chk("noecho_latency", 32'((to_cyc - trig_fall_cyc) >= 1999 && (to_cyc - trig_fall_cyc) <= 2001), 1);
        chk("noecho_distance_kept", 32'(Distance), 11);
        chk("noecho_no_valid", valid_cnt, nv);
        wait_for("noecho_next_trig", 0, r0 + 2, 4000);
        chk("noecho_period", trig_rise_cyc - prev_rise_cyc, PERIOD_CYCLES);

        // Saturation: 1600 cycles -> 800 us -> 266 cm -> 255
        measure("saturate", 1600, 255);

        // Stuck echo: timeout, then no trigger until echo drops
        nv = valid_cnt;
        r0 = trig_rises + 1;
        wait_for("stuck_trig_fall", 1, trig_falls + 1, 7000);
        tick(20);
        Echo = 1'b1;
        wait_for("stuck_timeout_wait", 3, to_cnt + 1, 2500);
        chk("stuck_distance_kept", 32'(Distance), 255);
        chk("stuck_no_valid", valid_cnt, nv);
        tick(trig_rise_cyc + 6000 - cyc);
        chk("stuck_no_retrigger", trig_rises, r0);
        Echo = 1'b0;
        d = cyc;
        wait_for("stuck_retrigger_wait", 0, r0 + 1, 50);
        chk("stuck_retrigger_delay", trig_rise_cyc - d, 3);

        // Enable dropped during MEASURE: measurement completes, then IDLE
        r0 = trig_rises;
        nv = valid_cnt + 1;
        b0 = busy_falls;
        wait_for("en_trig_fall", 1, trig_falls + 1, 50);
        tick(20);
        Echo = 1'b1;
        tick(30);
        Enable = 1'b0;
        tick(30);
        Echo = 1'b0;
        wait_for("en_valid_wait", 2, nv, 50);
        chk("en_distance", 32'(Distance), 10);
        wait_for("en_busy_fall_wait", 4, b0 + 1, 6000);
        chk("en_busy_fall_time", busy_fall_cyc - trig_rise_cyc, PERIOD_CYCLES);
        chk("en_busy_low", 32'(Busy), 0);
        tick(6000);
        chk("en_no_retrigger", trig_rises, r0);
        chk("en_still_idle", 32'(Busy), 0);

        // Reset mid-MEASURE
        Enable = 1'b1;
        wait_for("rm_trig_rise", 0, r0 + 1, 5);
        wait_for("rm_trig_fall", 1, trig_falls + 1, 20);
        tick(20);
        Echo = 1'b1;
        tick(30);
        nv = valid_cnt;
        nt = to_cnt;
        chk("rm_pre_distance", 32'(Distance), 10);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("rm_async_trig", 32'(Trig), 0);
        chk("rm_async_distance", 32'(Distance), 0);
        chk("rm_async_busy", 32'(Busy), 0);
        Echo = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tick(1);
        chk("rm_release_trig", 32'(Trig), 1);

        // Reset while Trig is high: Trig drops without a clock edge
        tick(2);
        chk("rt_trig_high", 32'(Trig), 1);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("rt_async_trig", 32'(Trig), 0);
        chk("rt_async_busy", 32'(Busy), 0);
        Enable = 1'b0;
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        tick(5);
        chk("rst_discard_valid", valid_cnt, nv);
        chk("rst_discard_timeout", to_cnt, nt);
        chk("rst_idle_trig", 32'(Trig), 0);
        chk("strobe_exclusive_single", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
